// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and optional skid slot.
// Bubbles carry zeroed control bits so a squashed or empty slot can never write state.
module ex_mem_pipe_stage #(
  parameter int CTRL_W     = 4,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [REG_ADDR_W-1:0] in_wreg,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [REG_ADDR_W-1:0] out_wreg,
  output logic [DATA_W-1:0]     out_alu,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     wdata;
  } entry_t;

  entry_t in_ent;
  entry_t head_q, head_d;
  logic   head_vld_q, head_vld_d;
  logic   accept, rel;

  assign in_ent = '{ctrl: in_ctrl, wreg: in_wreg, alu: in_alu, wdata: in_wdata};
  assign accept = in_valid & in_ready;
  assign rel    = head_vld_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  generate
    if (SKID == 0) begin : g_single
      always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        if (flush) begin
          head_vld_d = 1'b0;
        end else if (accept) begin
          head_d     = in_ent;
          head_vld_d = 1'b1;
        end else if (rel) begin
          head_vld_d = 1'b0;
        end
      end

      assign in_ready  = ~reset & (~head_vld_q | out_ready);
      assign occupancy = {1'b0, head_vld_q};
    end else begin : g_skid
      entry_t skid_q, skid_d;
      logic   skid_vld_q, skid_vld_d;
      logic   rdy_q;

      // The skid slot is only ever filled behind a valid head, so the
      // {skid, head} valid pair never takes the value 2'b10.
      always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
          head_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end else begin
          case ({skid_vld_q, head_vld_q})
            2'b00: begin
              if (accept) begin
                head_d     = in_ent;
                head_vld_d = 1'b1;
              end
            end
            2'b01: begin
              if (accept && rel) begin
                head_d = in_ent;
              end else if (accept) begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
              end else if (rel) begin
                head_vld_d = 1'b0;
              end
            end
            2'b11: begin
              if (rel) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      // rdy_q resets high; reset itself gates the port so in_ready is low
      // during reset and high in the first cycle after it drops.
      always_ff @(posedge clk) begin
        if (reset) begin
          skid_q     <= '0;
          skid_vld_q <= 1'b0;
          rdy_q      <= 1'b1;
        end else begin
          skid_q     <= skid_d;
          skid_vld_q <= skid_vld_d;
          rdy_q      <= ~(head_vld_d & skid_vld_d);
        end
      end

      assign in_ready  = rdy_q & ~reset;
      assign occupancy = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
    end
  endgenerate

  assign out_valid = head_vld_q;
  assign out_ctrl  = head_vld_q ? head_q.ctrl : '0;
  assign out_wreg  = head_q.wreg;
  assign out_alu   = head_q.alu;
  assign out_wdata = head_q.wdata;

endmodule
